// File: rtl/spart_param.sv
// spart_param: bus-mapped UART with TX/RX FIFOs, sticky status bits and a programmable bit divisor.
module spart_param #(
  parameter int DEPTH = 8,
  parameter int DATA_BITS = 8,
  parameter int PARITY = 0,
  parameter int STOP_BITS = 1,
  parameter logic [12:0] DIV_RESET = 13'h01B2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic iocs_n,
  input  logic iorw_n,
  input  logic [1:0] ioaddr,
  inout  wire  [7:0] databus,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic irq,
  output logic TX,
  input  logic RX
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;
  logic [12:0] div, per, tcnt, rcnt;
  logic [7:0] din, rdata, status;
  logic [3:0] clr;
  logic wr, rd, rx_ovr, frame_err, par_err, tx_ovf;
  logic [DATA_BITS-1:0] tmem [DEPTH];
  logic [DATA_BITS-1:0] rmem [DEPTH];
  logic [AW:0] twp, trp, rwp, rrp;
  logic tx_empty, tx_full, rx_empty, rx_full, tx_push, tx_pop, rx_push, rx_pop;
  state_t ts, rs;
  logic [2:0] tidx, ridx;
  logic [DATA_BITS-1:0] tsh, rsh, thead, rhead;
  logic tpar, tsb, rperr, r1, r2, r3, rx_done;

  assign din = databus;
  assign wr = !iocs_n && !iorw_n;
  assign rd = !iocs_n && iorw_n;
  assign databus = rd ? rdata : 8'bz;
  assign per = (div < 13'd2) ? 13'd2 : div;
  assign tx_empty = twp == trp;
  assign rx_empty = rwp == rrp;
  assign tx_full = (twp[AW] != trp[AW]) && (twp[AW-1:0] == trp[AW-1:0]);
  assign rx_full = (rwp[AW] != rrp[AW]) && (rwp[AW-1:0] == rrp[AW-1:0]);
  assign tx_count = twp - trp;
  assign rx_count = rwp - rrp;
  assign thead = tmem[trp[AW-1:0]];
  assign rhead = rmem[rrp[AW-1:0]];
  // a new frame starts straight out of IDLE or at the end of the last stop bit
  assign tx_pop = !tx_empty && (ts == IDLE || (ts == STOP && tcnt == 13'd0 && tsb == 1'(STOP_BITS - 1)));
  assign tx_push = wr && ioaddr == 2'd0 && (!tx_full || tx_pop);
  assign rx_done = rs == STOP && rcnt == 13'd0;
  assign rx_pop = rd && ioaddr == 2'd0 && !rx_empty;
  assign rx_push = rx_done && (!rx_full || rx_pop);
  assign clr = (wr && ioaddr == 2'd1) ? din[7:4] : 4'd0;
  assign status = {rx_ovr, frame_err, par_err, tx_ovf, tx_full, tx_empty, rx_full, rx_empty};
  assign rdata = ioaddr == 2'd0 ? (rx_empty ? 8'd0 : 8'(rhead)) :
                 ioaddr == 2'd1 ? status :
                 ioaddr == 2'd2 ? div[7:0] : {3'b0, div[12:8]};
  assign irq = !rx_empty | rx_ovr | frame_err | par_err | tx_ovf;

  always_ff @(posedge clk) begin
    if (tx_push) tmem[twp[AW-1:0]] <= din[DATA_BITS-1:0];
    if (rx_push) rmem[rwp[AW-1:0]] <= rsh;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      twp <= '0;
      trp <= '0;
      rwp <= '0;
      rrp <= '0;
      div <= DIV_RESET;
      rx_ovr <= 1'b0;
      frame_err <= 1'b0;
      par_err <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      twp <= twp + {{AW{1'b0}}, tx_push};
      trp <= trp + {{AW{1'b0}}, tx_pop};
      rwp <= rwp + {{AW{1'b0}}, rx_push};
      rrp <= rrp + {{AW{1'b0}}, rx_pop};
      if (wr && ioaddr == 2'd2) div[7:0] <= din;
      if (wr && ioaddr == 2'd3) div[12:8] <= din[4:0];
      rx_ovr <= (rx_ovr && !clr[3]) || (rx_done && rx_full && !rx_pop);
      frame_err <= (frame_err && !clr[2]) || (rx_done && !r2);
      par_err <= (par_err && !clr[1]) || (rx_done && rperr);
      tx_ovf <= (tx_ovf && !clr[0]) || (wr && ioaddr == 2'd0 && tx_full && !tx_pop);
    end
  end

  // each bit reloads the counter from the live divisor, so DIV changes land on bit boundaries
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts <= IDLE;
      TX <= 1'b1;
      tcnt <= '0;
      tidx <= '0;
      tsh <= '0;
      tpar <= 1'b0;
      tsb <= 1'b0;
    end else if (tx_pop) begin
      ts <= START;
      TX <= 1'b0;
      tcnt <= per - 13'd1;
      tsh <= thead;
      tpar <= ^thead ^ (PARITY == 2);
    end else if (ts != IDLE) begin
      if (tcnt != 13'd0) tcnt <= tcnt - 13'd1;
      else begin
        tcnt <= per - 13'd1;
        case (ts)
          START: begin
            ts <= DATA;
            TX <= tsh[0];
            tsh <= tsh >> 1;
            tidx <= '0;
          end
          DATA: begin
            if (tidx == 3'(DATA_BITS - 1)) begin
              ts <= (PARITY != 0) ? PAR : STOP;
              TX <= (PARITY != 0) ? tpar : 1'b1;
              tsb <= 1'b0;
            end else begin
              tidx <= tidx + 3'd1;
              TX <= tsh[0];
              tsh <= tsh >> 1;
            end
          end
          PAR: begin
            ts <= STOP;
            TX <= 1'b1;
            tsb <= 1'b0;
          end
          STOP: begin
            if (tsb == 1'(STOP_BITS - 1)) ts <= IDLE;
            else tsb <= 1'b1;
          end
          default: ts <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rs <= IDLE;
      rcnt <= '0;
      ridx <= '0;
      rsh <= '0;
      rperr <= 1'b0;
      r1 <= 1'b1;
      r2 <= 1'b1;
      r3 <= 1'b1;
    end else begin
      r1 <= RX;
      r2 <= r1;
      r3 <= r2;
      case (rs)
        IDLE: begin
          if (r3 && !r2) begin
            rs <= START;
            rcnt <= (per >> 1) - 13'd1;
          end
        end
        START: begin
          if (rcnt != 13'd0) rcnt <= rcnt - 13'd1;
          else begin
            rs <= r2 ? IDLE : DATA;
            rcnt <= per - 13'd1;
            ridx <= '0;
          end
        end
        DATA: begin
          if (rcnt != 13'd0) rcnt <= rcnt - 13'd1;
          else begin
            rcnt <= per - 13'd1;
            rsh <= {r2, rsh[DATA_BITS-1:1]};
            ridx <= ridx + 3'd1;
            if (ridx == 3'(DATA_BITS - 1)) rs <= (PARITY != 0) ? PAR : STOP;
          end
        end
        PAR: begin
          if (rcnt != 13'd0) rcnt <= rcnt - 13'd1;
          else begin
            rcnt <= per - 13'd1;
            rperr <= (^rsh ^ r2) != (PARITY == 2);
            rs <= STOP;
          end
        end
        STOP: begin
          if (rcnt != 13'd0) rcnt <= rcnt - 13'd1;
          else rs <= IDLE;
        end
        default: rs <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spart_param.sv
// tb_spart_param: scoreboard bench for spart_param, a default instance plus a PARITY=1 instance.
module tb_spart_param;
  logic clk = 0, rst_n = 0, cs_m = 1, cs_p = 1, iorw_n = 1, loop = 0, rx_drv = 1, rx_p = 1, en_m = 0, en_p = 0;
  logic [1:0] ioaddr = 0;
  logic [7:0] bus_o = 0, q, b;
  wire [7:0] bus_m, bus_p;
  logic [3:0] txc_m, rxc_m, txc_p, rxc_p;
  logic irq_m, irq_p, tx_m, tx_p, rx_m;
  int checks = 0, errors = 0, bdiv = 4, lat, n;
  logic [7:0] rxq_m[$], rxq_p[$], txq[$];
  logic tbq[$];

  assign bus_m = en_m ? bus_o : 8'bz;
  assign bus_p = en_p ? bus_o : 8'bz;
  assign rx_m = loop ? tx_m : rx_drv;
  always #5 clk = ~clk;

  spart_param u_main (.clk(clk), .rst_n(rst_n), .iocs_n(cs_m), .iorw_n(iorw_n), .ioaddr(ioaddr),
    .databus(bus_m), .tx_count(txc_m), .rx_count(rxc_m), .irq(irq_m), .TX(tx_m), .RX(rx_m));
  spart_param #(.PARITY(1)) u_par (.clk(clk), .rst_n(rst_n), .iocs_n(cs_p), .iorw_n(iorw_n), .ioaddr(ioaddr),
    .databus(bus_p), .tx_count(txc_p), .rx_count(rxc_p), .irq(irq_p), .TX(tx_p), .RX(rx_p));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic acc(input bit p, input bit rw, input logic [1:0] a, input logic [7:0] d, output logic [7:0] r);
    iorw_n = rw;
    ioaddr = a;
    bus_o = d;
    if (p) begin cs_p = 0; en_p = !rw; end
    else begin cs_m = 0; en_m = !rw; end
    #1 r = p ? bus_p : bus_m;
    @(negedge clk);
    cs_m = 1; cs_p = 1; en_m = 0; en_p = 0;
  endtask

  task automatic wr(input bit p, input logic [1:0] a, input logic [7:0] d);
    logic [7:0] r;
    acc(p, 1'b0, a, d, r);
  endtask

  task automatic rd(input bit p, input logic [1:0] a, output logic [7:0] r);
    acc(p, 1'b1, a, 8'h00, r);
  endtask

  task automatic set_line(input bit p, input logic v);
    if (p) rx_p = v;
    else rx_drv = v;
  endtask

  task automatic send(input bit p, input logic [7:0] d, input logic stop, input logic bad);
    set_line(p, 1'b0);
    repeat (bdiv) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(p, d[i]);
      repeat (bdiv) @(negedge clk);
    end
    if (p) begin
      set_line(p, ^d ^ bad);
      repeat (bdiv) @(negedge clk);
    end
    set_line(p, stop);
    repeat (bdiv) @(negedge clk);
    set_line(p, 1'b1);
    repeat (2 * bdiv) @(negedge clk);
  endtask

  task automatic tx_cap(output logic [7:0] c);
    int k = 0;
    c = 0;
    while (tx_m !== 1'b0 && k < 200) begin @(negedge clk); k++; end
    check("tx_frame_start", k < 200, 1);
    repeat (bdiv / 2) @(negedge clk);
    check("tx_start_bit", tx_m, 0);
    for (int i = 0; i < 8; i++) begin
      repeat (bdiv) @(negedge clk);
      c[i] = tx_m;
    end
    repeat (bdiv) @(negedge clk);
    check("tx_stop_bit", tx_m, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_tx", tx_m, 1);
    check("rst_counts", {txc_m, rxc_m}, 0);
    check("rst_irq", irq_m, 0);
    rst_n = 1;
    @(negedge clk);
    rd(0, 2'd1, q); check("rst_status", q, 8'h05);
    rd(0, 2'd2, q); check("rst_dbl", q, 8'hB2);
    rd(0, 2'd3, q); check("rst_dbh", q, 8'h01);
    wr(0, 2'd2, 8'd4);
    wr(0, 2'd3, 8'd0);
    rd(0, 2'd2, q); check("dbl_write", q, 8'h04);

    tbq.push_back(1'b0);
    for (int i = 0; i < 8; i++) begin
      b = 8'hA5;
      tbq.push_back(b[i]);
    end
    tbq.push_back(1'b1);
    wr(0, 2'd0, 8'hA5);
    check("a5_count_pushed", txc_m, 1);
    n = 0;
    while (tx_m !== 1'b0 && n < 3) begin @(negedge clk); n++; end
    check("a5_start_latency", n < 3, 1);
    check("a5_count_popped", txc_m, 0);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("a5_bit%0d", i), tx_m, tbq.pop_front());
      repeat (bdiv) @(negedge clk);
    end

    fork
      for (int f = 0; f < 9; f++) begin
        tx_cap(q);
        check($sformatf("tx_frame%0d", f), q, txq.size() ? txq.pop_front() : 8'hxx);
      end
      begin
        txq.push_back(8'h3F);
        wr(0, 2'd0, 8'h3F);
        for (int i = 0; i < 9; i++) begin
          if (i < 8) txq.push_back(8'h40 + 8'(i));
          wr(0, 2'd0, 8'h40 + 8'(i));
        end
        check("ovf_count", txc_m, 8);
        rd(0, 2'd1, q); check("ovf_status", q, 8'h19);
        check("ovf_irq", irq_m, 1);
        wr(0, 2'd1, 8'h10);
        rd(0, 2'd1, q); check("ovf_cleared", q, 8'h09);
        check("ovf_irq_clear", irq_m, 0);
      end
    join
    check("tx_drained", txc_m, 0);

    loop = 1;
    rxq_m.push_back(8'h3C);
    wr(0, 2'd0, 8'h3C);
    n = 0;
    while (rxc_m == 0 && n < 200) begin @(negedge clk); n++; end
    check("loop_arrival", n < 200, 1);
    check("loop_count", rxc_m, 1);
    check("loop_irq", irq_m, 1);
    rd(0, 2'd0, q); check("loop_data", q, rxq_m.pop_front());
    rd(0, 2'd1, q); check("loop_status", q, 8'h05);
    repeat (2 * bdiv) @(negedge clk);
    loop = 0;

    rxq_m.push_back(8'h5A);
    send(0, 8'h5A, 1'b0, 1'b0);
    rd(0, 2'd1, q); check("ferr_status", q, 8'h44);
    rd(0, 2'd0, q); check("ferr_data", q, rxq_m.pop_front());
    wr(0, 2'd1, 8'hF0);
    rd(0, 2'd1, q); check("ferr_cleared", q, 8'h05);

    wr(1, 2'd2, 8'd4);
    wr(1, 2'd3, 8'd0);
    rxq_p.push_back(8'h33);
    send(1, 8'h33, 1'b1, 1'b0);
    rd(1, 2'd1, q); check("par_good_status", q, 8'h04);
    rd(1, 2'd0, q); check("par_good_data", q, rxq_p.pop_front());
    rxq_p.push_back(8'h33);
    send(1, 8'h33, 1'b1, 1'b1);
    rd(1, 2'd1, q); check("par_bad_status", q, 8'h24);
    check("par_bad_irq", irq_p, 1);
    rd(1, 2'd0, q); check("par_bad_data", q, rxq_p.pop_front());
    check("par_count", rxc_p, 0);

    rxq_m.push_back(8'hC0);
    fork
      send(0, 8'hC0, 1'b1, 1'b0);
      begin
        lat = 0;
        while (rxc_m == 0 && lat < 300) begin @(negedge clk); lat++; end
      end
    join
    check("rx_latency_bound", lat < 300, 1);
    for (int i = 1; i < 8; i++) begin
      rxq_m.push_back(8'hC0 + 8'(i));
      send(0, 8'hC0 + 8'(i), 1'b1, 1'b0);
    end
    check("full_count", rxc_m, 8);
    rd(0, 2'd1, q); check("full_status", q, 8'h06);
    send(0, 8'hEE, 1'b1, 1'b0);
    check("ovr_count", rxc_m, 8);
    rd(0, 2'd1, q); check("ovr_status", q, 8'h86);
    wr(0, 2'd1, 8'h80);
    fork
      send(0, 8'h77, 1'b1, 1'b0);
      begin
        repeat (lat - 1) @(negedge clk);
        rd(0, 2'd0, q);
        check("sim_pop_data", q, rxq_m.pop_front());
        check("sim_count", rxc_m, 8);
      end
    join
    rxq_m.push_back(8'h77);
    rd(0, 2'd1, q); check("sim_status", q, 8'h06);
    while (rxq_m.size() != 0) begin
      rd(0, 2'd0, q);
      check("drain_data", q, rxq_m.pop_front());
    end
    rd(0, 2'd1, q); check("drain_status", q, 8'h05);

    wr(0, 2'd0, 8'h00);
    wr(0, 2'd0, 8'h11);
    repeat (10) @(negedge clk);
    check("pre_rst_tx", tx_m, 0);
    check("pre_rst_count", txc_m, 1);
    rst_n = 0;
    #1;
    check("mid_rst_tx", tx_m, 1);
    check("mid_rst_counts", {txc_m, rxc_m}, 0);
    check("mid_rst_irq", irq_m, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    rd(0, 2'd2, q); check("post_rst_dbl", q, 8'hB2);
    rd(0, 2'd3, q); check("post_rst_dbh", q, 8'h01);
    rd(0, 2'd1, q); check("post_rst_status", q, 8'h05);
    repeat (60) @(negedge clk);
    check("post_rst_tx_idle", tx_m, 1);
    check("post_rst_tx_count", txc_m, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
